// File: rtl/sdr_app_master_pkg.sv
// Shared types and constants for the SDRAM application traffic master.
package sdr_app_master_pkg;

  localparam int ADDR_W = 26;
  localparam int LEN_W  = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Increment a 16-bit counter, holding at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sdr_pattern_chk.sv
// Pattern word generator (seed + beat) and read-data comparator.
module sdr_pattern_chk
  import sdr_app_master_pkg::*;
#(
  parameter int APP_DW = 32
) (
  input  logic [APP_DW-1:0] seed,
  input  logic [LEN_W-1:0]  beat,
  input  logic [APP_DW-1:0] rd_data,
  output logic [APP_DW-1:0] pattern,
  output logic              match
);

  // Addition wraps naturally at 2^APP_DW.
  assign pattern = seed + APP_DW'(beat);
  assign match   = (rd_data == pattern);

endmodule

// File: rtl/sdr_app_master.sv
// SDRAM application master: issues one write-pattern or read-and-check burst
// per host command, with a no-progress watchdog and sticky error reporting.
module sdr_app_master
  import sdr_app_master_pkg::*;
#(
  parameter int APP_DW  = 32,
  parameter int APP_BW  = APP_DW / 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                sdram_clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr_n,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [APP_DW-1:0]   cmd_seed,
  output logic                app_req,
  output logic                app_req_wr_n,
  output logic                app_req_wrap,
  output logic [ADDR_W-1:0]   app_req_addr,
  output logic [LEN_W-1:0]    app_req_len,
  output logic [APP_DW-1:0]   app_wr_data,
  output logic [APP_BW-1:0]   app_wr_en_n,
  input  logic                app_req_ack,
  input  logic                app_wr_next_req,
  input  logic                app_rd_valid,
  input  logic                app_last_rd,
  input  logic                app_last_wr,
  input  logic [APP_DW-1:0]   app_rd_data,
  output logic                done,
  output logic                err,
  output logic                timeout,
  output logic [15:0]         err_cnt
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e              state_r, state_nxt;
  logic [LEN_W-1:0]    beat_r, beat_nxt;
  logic [CW-1:0]       cyc_r, cyc_nxt;
  logic [ADDR_W-1:0]   addr_r, addr_nxt;
  logic [LEN_W-1:0]    len_r, len_nxt;
  logic                wr_n_r, wr_n_nxt;
  logic [APP_DW-1:0]   seed_r, seed_nxt;
  logic                err_r, err_nxt;
  logic                to_r, to_nxt;
  logic [15:0]         err_cnt_r, err_cnt_nxt;
  logic                cmd_ready_r, app_req_r, done_r;

  logic [APP_DW-1:0]   pattern_s;
  logic                match_s;
  logic                beat_lt_len_s;
  logic [LEN_W-1:0]    beat_inc_s;
  logic [CW-1:0]       cyc_inc_s;
  logic                progress_s;
  logic                to_hit_s;

  sdr_pattern_chk #(.APP_DW(APP_DW)) u_pattern_chk (
    .seed    (seed_r),
    .beat    (beat_r),
    .rd_data (app_rd_data),
    .pattern (pattern_s),
    .match   (match_s)
  );

  assign beat_lt_len_s = (beat_r < len_r);
  assign beat_inc_s    = beat_r + 9'd1;
  assign cyc_inc_s     = cyc_r + CW'(1);
  assign progress_s    = app_req_ack | app_wr_next_req | app_rd_valid;
  assign to_hit_s      = !progress_s && (cyc_r == CW'(TIMEOUT - 1));

  // Next-state, beat/watchdog counters and status flag updates.
  always_comb begin
    state_nxt   = state_r;
    beat_nxt    = beat_r;
    cyc_nxt     = cyc_r;
    addr_nxt    = addr_r;
    len_nxt     = len_r;
    wr_n_nxt    = wr_n_r;
    seed_nxt    = seed_r;
    err_nxt     = err_r;
    to_nxt      = to_r;
    err_cnt_nxt = err_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          addr_nxt    = cmd_addr;
          len_nxt     = cmd_len;
          wr_n_nxt    = cmd_wr_n;
          seed_nxt    = cmd_seed;
          err_nxt     = 1'b0;
          to_nxt      = 1'b0;
          err_cnt_nxt = 16'd0;
          beat_nxt    = 9'd0;
          cyc_nxt     = '0;
          if (cmd_len == 9'd0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_REQ;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        // The controller may pull the first write word before acking.
        if (!wr_n_r && app_wr_next_req && beat_lt_len_s) begin
          beat_nxt = beat_inc_s;
        end else begin
          beat_nxt = beat_r;
        end
        cyc_nxt = progress_s ? '0 : cyc_inc_s;
        if (app_req_ack) begin
          state_nxt = wr_n_r ? ST_RDATA : ST_WDATA;
        end else if (to_hit_s) begin
          to_nxt    = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_REQ;
        end
      end
      ST_WDATA: begin
        if (app_wr_next_req && beat_lt_len_s) begin
          beat_nxt = beat_inc_s;
        end else begin
          beat_nxt = beat_r;
        end
        cyc_nxt = progress_s ? '0 : cyc_inc_s;
        if (app_last_wr || (beat_nxt == len_r)) begin
          state_nxt = ST_DONE;
        end else if (to_hit_s) begin
          to_nxt    = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_WDATA;
        end
      end
      ST_RDATA: begin
        if (app_rd_valid && beat_lt_len_s) begin
          beat_nxt = beat_inc_s;
          if (!match_s) begin
            err_nxt     = 1'b1;
            err_cnt_nxt = sat_inc16(err_cnt_r);
          end else begin
            err_nxt     = err_r;
          end
        end else begin
          beat_nxt = beat_r;
        end
        cyc_nxt = progress_s ? '0 : cyc_inc_s;
        if (app_last_rd || (beat_nxt == len_r)) begin
          state_nxt = ST_DONE;
        end else if (to_hit_s) begin
          to_nxt    = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_RDATA;
        end
      end
      ST_DONE: begin
        cyc_nxt   = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, latched command fields, counters and registered handshake outputs.
  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      beat_r      <= 9'd0;
      cyc_r       <= '0;
      addr_r      <= 26'd0;
      len_r       <= 9'd0;
      wr_n_r      <= 1'b0;
      seed_r      <= '0;
      err_r       <= 1'b0;
      to_r        <= 1'b0;
      err_cnt_r   <= 16'd0;
      cmd_ready_r <= 1'b0;
      app_req_r   <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      beat_r      <= beat_nxt;
      cyc_r       <= cyc_nxt;
      addr_r      <= addr_nxt;
      len_r       <= len_nxt;
      wr_n_r      <= wr_n_nxt;
      seed_r      <= seed_nxt;
      err_r       <= err_nxt;
      to_r        <= to_nxt;
      err_cnt_r   <= err_cnt_nxt;
      cmd_ready_r <= (state_nxt == ST_IDLE);
      app_req_r   <= (state_nxt == ST_REQ);
      done_r      <= (state_r == ST_DONE);
    end
  end

  assign cmd_ready    = cmd_ready_r;
  assign app_req      = app_req_r;
  assign app_req_wr_n = wr_n_r;
  assign app_req_wrap = 1'b0;
  assign app_req_addr = addr_r;
  assign app_req_len  = len_r;
  assign app_wr_data  = pattern_s;
  assign app_wr_en_n  = {APP_BW{1'b0}};
  assign done         = done_r;
  assign err          = err_r;
  assign timeout      = to_r;
  assign err_cnt      = err_cnt_r;

endmodule

// File: doc/sdr_app_master.md
SDR_APP_MASTER -- requirements
Module: sdr_app_master

Interface
REQ-001 Parameter APP_DW, default 32, SHALL set the application data width.
REQ-002 Parameter APP_BW, default APP_DW/8, SHALL set the byte-enable width.
REQ-003 Parameter TIMEOUT, default 1023, SHALL set the no-progress cycle limit.
REQ-004 sdram_clk  in  1  sole clock; all logic SHALL be rising-edge triggered.
REQ-005 reset_n  in  1  reset; asynchronous assert, active-low.
REQ-006 cmd_valid  in  1  host command valid.
REQ-007 cmd_ready  out  1  host command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_wr_n  in  1  0 = write burst, 1 = read-and-check burst.
REQ-009 cmd_addr  in  26  start address.
REQ-010 cmd_len  in  9  burst length in APP_DW words.
REQ-011 cmd_seed  in  APP_DW  data-pattern seed.
REQ-012 app_req, app_req_wr_n, app_req_wrap  out  1 each  request to the SDRAM controller.
REQ-013 app_req_addr  out  26, app_req_len  out  9  request address and length.
REQ-014 app_wr_data  out  APP_DW, app_wr_en_n  out  APP_BW  write data and byte enables.
REQ-015 app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd, app_last_wr  in  1 each  controller responses.
REQ-016 app_rd_data  in  APP_DW  read data.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 err  out  1  sticky mismatch flag; timeout  out  1  sticky timeout flag.
REQ-019 err_cnt  out  16  saturating mismatch count.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, WDATA, RDATA and DONE.
REQ-021 IDLE: cmd_ready=1; on handshake, latch addr/len/wr_n/seed, clear err, timeout and err_cnt, zero the beat counter, and go to REQ (cmd_len==0 goes directly to DONE with no app_req).
REQ-022 REQ: app_req=1 with latched fields; app_req_wrap SHALL be 0; app_req SHALL stay high until app_req_ack is sampled 1, then go to WDATA (write) or RDATA (read) on the next cycle.
REQ-023 Pattern word k SHALL be seed+k, modulo 2^APP_DW.
REQ-024 app_wr_data SHALL be combinationally seed+beat and app_wr_en_n SHALL be all-zero; each cycle with app_wr_next_req=1 in REQ or WDATA SHALL increment beat.
REQ-025 WDATA SHALL exit to DONE on the cycle that app_last_wr=1 or on the increment that makes beat==len, whichever comes first.
REQ-026 RDATA: each app_rd_valid=1 cycle SHALL compare app_rd_data with seed+beat; a mismatch sets err and increments err_cnt (saturating at 16'hFFFF); beat increments.
REQ-027 RDATA SHALL exit to DONE on the cycle that app_last_rd=1 or on the increment that makes beat==len, whichever comes first; a final-beat mismatch SHALL still be counted.
REQ-028 In REQ, WDATA and RDATA, a cycle counter SHALL reset on ack, app_wr_next_req or app_rd_valid and increment otherwise; on reaching TIMEOUT, set timeout, drop app_req and go to DONE.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE; cmd_ready=0 in every state except IDLE.
REQ-030 Beats beyond len, and app_wr_next_req/app_rd_valid arriving in IDLE or DONE, SHALL be ignored without a counter change.
REQ-031 Latency: the first app_req SHALL be asserted the cycle after the command handshake.

Reset
REQ-032 reset_n low SHALL immediately force IDLE with app_req=0, done=0, err=0, timeout=0, err_cnt=0, beat=0 and app_req_addr/app_req_len/app_req_wr_n=0; cmd_ready rises after release.
REQ-033 Reset mid-burst SHALL abandon the burst without emitting done.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the address width (26) and the length width (9); the data width comes from the existing APP_DW/APP_BW constants.
REQ-035 The pattern generate/compare (seed+beat adder and comparator) SHALL be one sub-module, sdr_pattern_chk.

Verification
REQ-036 Write addr 26'h000100, len 8, seed 32'hA000_0000: the controller sees words A0000000..A0000007, then done pulses once; err=0.
REQ-037 Read back the same burst: 8 app_rd_valid beats match, err_cnt=0, and done pulses when app_last_rd=1.
REQ-038 Read with beat 3 corrupted to 32'hDEADBEEF: err=1, err_cnt=1, and done still pulses.
REQ-039 Hold app_req_ack low for 1024 cycles (TIMEOUT=1023): timeout=1, app_req drops, and done pulses once.
REQ-040 Assert reset_n low at write beat 4 of 8: all outputs return to reset values with no done pulse, and a new command accepted after release runs normally.
REQ-041 cmd_len=0: done pulses 2 cycles after the handshake and app_req never rises.
